// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// One product/quotient bit per cycle; fixed WIDTH+2 cycle latency with a front-end stall interlock.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    // Handshake: start is a level from decode; it is accepted only in IDLE,
    // and while busy the stall output tells upstream to hold it.

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic               is_div_q;
    logic               neg_q;
    logic               rneg_q;
    logic               dz_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rs_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;

    logic               in_signed;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state != IDLE);
        stall = busy & (start | mf_req | mthi_en | mtlo_en);
    end

    // Operand conditioning: magnitudes for signed ops, raw values otherwise
    always_comb begin
        in_signed = ~op[0];
        rs_abs    = (in_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        rt_abs    = (in_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    end

    // Low half holds the multiplier (shifted out LSB first) or the dividend
    // (shifted out MSB first); high half is the partial product or remainder.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, b_q};
        if (!is_div_q) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction applied while in FIX
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
            res_hi = rs_q;
            res_lo = '1;
        end else begin
            res_hi = rem_fix;
            res_lo = quot_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rs_q     <= '0;
            acc      <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (mthi_en) hi_out <= mt_data;
                    if (mtlo_en) lo_out <= mt_data;
                    if (start) begin
                        is_div_q <= op[1];
                        neg_q    <= in_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        rneg_q   <= in_signed & op[1] & rs_data[WIDTH-1];
                        dz_q     <= op[1] & (rt_data == '0);
                        a_q      <= rs_abs;
                        b_q      <= rt_abs;
                        rs_q     <= rs_data;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? rs_abs : rt_abs)};
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi_out <= res_hi;
                    lo_out <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: a cycle-level arithmetic model checked every cycle,
// plus hand-computed HI/LO, latency and interlock expectations.
module tb_mips_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         mthi_en;
    logic         mtlo_en;
    logic [W-1:0] mt_data;
    logic         mf_req;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .mthi_en(mthi_en), .mtlo_en(mtlo_en), .mt_data(mt_data),
        .mf_req(mf_req), .busy(busy), .stall(stall), .done(done),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one op as {HI, LO}
    function automatic logic [2*W-1:0] model_result(input logic [1:0] o,
                                                     input logic [W-1:0] a,
                                                     input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = sa * sb; return p; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
            2'b10: begin
                if (b == '0) return {a, {W{1'b1}}};
                q = sa / sb; r = sa % sb;
                qv = q; rv = r;
                return {rv[W-1:0], qv[W-1:0]};
            end
            default: begin
                if (b == '0) return {a, {W{1'b1}}};
                qv = {32'b0, a} / {32'b0, b};
                rv = {32'b0, a} % {32'b0, b};
                return {rv[W-1:0], qv[W-1:0]};
            end
        endcase
    endfunction

    // Model: an accepted op occupies the unit for W+1 cycles, then HI/LO update
    int           remaining = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_done = 1'b0;
    logic [2*W-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; remaining = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else begin
                if (mthi_en) m_hi = mt_data;
                if (mtlo_en) m_lo = mt_data;
                if (start) begin
                    m_pend = model_result(op, rs_data, rt_data);
                    remaining = W + 1;
                end
            end
        end
    end

    // Compare process: every cycle once out of the first reset
    always @(negedge clk) begin
        bit m_busy;
        if (cmp_en) begin
            m_busy = (remaining > 0);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("stall", 32'(stall), 32'(m_busy & (start | mf_req | mthi_en | mtlo_en)));
            chk("done", 32'(done), 32'(m_done));
            chk("hi_out", hi_out, m_hi);
            chk("lo_out", lo_out, m_lo);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        int n;
        bit seen;
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        seen = 1'b0;
        while (n <= 40 && !seen) begin
            if (done) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        chk({name, " latency"}, 32'(n), 32'd34);
        chk({name, " hi"}, hi_out, exp_hi);
        chk({name, " lo"}, lo_out, exp_lo);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        mthi_en = 1'b0; mtlo_en = 1'b0; mt_data = '0; mf_req = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset hi", hi_out, 32'd0);
        chk("reset lo", lo_out, 32'd0);
        rst = 1'b0;
        tick();

        run_op("mult",      2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu",     2'b01, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div negdv", 2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu",      2'b11, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003);
        run_op("divu dz",   2'b11, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div dz",    2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("mult min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // Interlock with mf_req held, a second start in cycle 5, MTLO in cycle 10
        op = 2'b00; rs_data = 32'd3; rt_data = 32'd5; start = 1'b1;
        tick();
        start = 1'b0; mf_req = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            start   = (c == 5);
            rs_data = (c == 5) ? 32'd100 : 32'd3;
            mtlo_en = (c == 10);
            mt_data = (c == 10) ? 32'hDEAD : 32'd0;
            @(negedge clk);
            #1;
            chk("interlock stall", 32'(stall), (c <= 33) ? 32'd1 : 32'd0);
            if (c == 34) begin
                chk("interlock done", 32'(done), 32'd1);
                chk("interlock lo", lo_out, 32'd15);
                chk("interlock hi", hi_out, 32'd0);
            end
            tick();
        end
        start = 1'b0; mtlo_en = 1'b0; mf_req = 1'b0;
        tick();

        // MTHI/MTLO together in IDLE
        mthi_en = 1'b1; mtlo_en = 1'b1; mt_data = 32'h1234;
        tick();
        mthi_en = 1'b0; mtlo_en = 1'b0;
        chk("mt hi", hi_out, 32'h1234);
        chk("mt lo", lo_out, 32'h1234);

        // MTHI and start in the same cycle: MT lands first, result overwrites
        mthi_en = 1'b1; mt_data = 32'hAAAA; op = 2'b11; rs_data = 32'd7; rt_data = 32'd2;
        start = 1'b1;
        tick();
        mthi_en = 1'b0; start = 1'b0;
        chk("mt+start hi early", hi_out, 32'hAAAA);
        repeat (33) tick();
        chk("mt+start done", 32'(done), 32'd1);
        chk("mt+start hi", hi_out, 32'd1);
        chk("mt+start lo", lo_out, 32'd3);
        tick();

        // Reset mid-operation
        op = 2'b00; rs_data = 32'd5; rt_data = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hi", hi_out, 32'd0);
        chk("abort lo", lo_out, 32'd0);
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) dcount++;
            tick();
        end
        chk("abort no done", 32'(dcount), 32'd0);
        run_op("multu after", 2'b01, 32'd2, 32'd2, 32'd0, 32'd4);

        // Final report
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
